// File: rtl/qmult_dot_accum.sv
`default_nettype none
// ============================================================================
// Module      : qmult_dot_accum
// Description : Accumulates a stream of LEN sign-magnitude Q-format products
//               over a valid/ready handshake. It returns one saturated
//               sign-magnitude dot-product result per run.
// Ports       : i_clk, i_rst     - clock, synchronous active-high reset
//               i_start          - begin a new run (honoured in IDLE only)
//               i_product, i_ovr - product word and its overflow flag
//               i_valid/o_ready  - product handshake
//               o_sum, o_ovr     - saturated result and sticky overflow
//               o_valid/i_ready  - result handshake
//               o_count          - products accepted in the current run
// Revision    : 1.0 - initial release
// ============================================================================
module qmult_dot_accum #(
  parameter int Q   = 15,
  parameter int N   = 32,
  parameter int LEN = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [N-1:0] i_product,
  input  logic         i_ovr,
  input  logic         i_valid,
  output logic         o_ready,
  output logic [N-1:0] o_sum,
  output logic         o_ovr,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [15:0]  o_count
);

  // Enough headroom that LEN full-scale terms can never wrap.
  localparam int ACC_W = N + $clog2(LEN);
  localparam logic [15:0] LAST_COUNT = 16'(LEN - 1);
  localparam logic [ACC_W-1:0] MAX_MAG = {{(ACC_W-N+1){1'b0}}, {(N-1){1'b1}}};

  if (LEN < 1 || LEN > 65535 || Q > N - 1) begin : g_param_error
    $error("qmult_dot_accum: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [ACC_W-1:0] acc;
  logic [15:0]      count;
  logic             sticky;
  logic [N-1:0]     sum_reg;
  logic             ovr_reg;

  logic [ACC_W-1:0] mag_ext;
  logic [ACC_W-1:0] term;
  logic [ACC_W-1:0] acc_sum;
  logic [ACC_W-1:0] acc_abs;
  logic             acc_neg;
  logic             saturate;
  logic [N-2:0]     res_mag;
  logic             sticky_next;
  logic             accept;
  logic             last_accept;

  // Sign-magnitude to two's complement. A negative zero becomes -0 = 0.
  assign mag_ext = {{(ACC_W-N+1){1'b0}}, i_product[N-2:0]};
  assign term    = i_product[N-1] ? (~mag_ext + 1'b1) : mag_ext;
  assign acc_sum = acc + term;

  // The result is converted back to sign-magnitude. A zero sum is never
  // negative, so the sign bit is 0 for a zero result without a special case.
  assign acc_neg  = acc_sum[ACC_W-1];
  assign acc_abs  = acc_neg ? (~acc_sum + 1'b1) : acc_sum;
  assign saturate = (acc_abs > MAX_MAG);
  assign res_mag  = saturate ? {(N-1){1'b1}} : acc_abs[N-2:0];

  assign sticky_next = sticky | i_ovr;
  assign accept      = i_valid && (state == ACCUM);
  assign last_accept = accept && (count == LAST_COUNT);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    o_ready    = 1'b0;
    o_valid    = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        o_ready = 1'b1;
        if (i_valid && (count == LAST_COUNT)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        o_valid = 1'b1;
        if (i_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc     <= '0;
      count   <= '0;
      sticky  <= 1'b0;
      sum_reg <= '0;
      ovr_reg <= 1'b0;
    end else if ((state == IDLE) && i_start) begin
      acc    <= '0;
      count  <= '0;
      sticky <= 1'b0;
    end else if (accept) begin
      acc    <= acc_sum;
      count  <= count + 16'd1;
      sticky <= sticky_next;
      if (last_accept) begin
        sum_reg <= {acc_neg, res_mag};
        ovr_reg <= sticky_next | saturate;
      end
    end
  end

  assign o_sum   = sum_reg;
  assign o_ovr   = ovr_reg;
  assign o_count = count;

endmodule
`default_nettype wire

// File: tb/tb_qmult_dot_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_qmult_dot_accum
// Description : Directed self-checking bench for qmult_dot_accum with
//               Q=19, N=32, LEN=4. The expected values are hand-computed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qmult_dot_accum;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] product;
  logic        p_ovr;
  logic        p_valid;
  logic        ready;
  logic [31:0] sum;
  logic        sum_ovr;
  logic        sum_valid;
  logic        ds_ready;
  logic [15:0] count;

  int checks   = 0;
  int failures = 0;

  qmult_dot_accum #(.Q(19), .N(32), .LEN(4)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_start   (start),
    .i_product (product),
    .i_ovr     (p_ovr),
    .i_valid   (p_valid),
    .o_ready   (ready),
    .o_sum     (sum),
    .o_ovr     (sum_ovr),
    .o_valid   (sum_valid),
    .i_ready   (ds_ready),
    .o_count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // A full run is driven on falling edges and checked on falling edges.
  // The products are packed element 0 at bits [31:0]. gap is the number of
  // idle cycles between accepts. hold is the number of DONE cycles with
  // i_ready low, with i_start pulsed during them.
  task automatic run_vec(input string nm, input logic [127:0] vals, input logic [3:0] ovrs,
                         input int gap, input int hold,
                         input logic [31:0] exp_sum, input logic exp_ovr);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      p_valid = 1'b1;
      product = vals[k*32 +: 32];
      p_ovr   = ovrs[k];
      if (k == 3) check_eq({nm, "_valid_early"}, 32'(sum_valid), 32'd0);
      @(negedge clk);
      p_valid = 1'b0;
      p_ovr   = 1'b0;
      product = 32'hDEAD_BEEF;
      if (k < 3) repeat (gap) @(negedge clk);
    end
    check_eq({nm, "_valid"}, 32'(sum_valid), 32'd1);
    check_eq({nm, "_sum"},   sum,            exp_sum);
    check_eq({nm, "_ovr"},   32'(sum_ovr),   32'(exp_ovr));
    check_eq({nm, "_count"}, 32'(count),     32'd4);
    for (int h = 0; h < hold; h++) begin
      start = h[0];
      @(negedge clk);
      check_eq({nm, "_hold_valid"}, 32'(sum_valid), 32'd1);
      check_eq({nm, "_hold_sum"},   sum,            exp_sum);
      check_eq({nm, "_hold_count"}, 32'(count),     32'd4);
    end
    ds_ready = 1'b1;
    start    = (hold > 0);
    @(negedge clk);
    ds_ready = 1'b0;
    start    = 1'b0;
    check_eq({nm, "_valid_drop"}, 32'(sum_valid), 32'd0);
    check_eq({nm, "_idle_ready"}, 32'(ready),     32'd0);
    check_eq({nm, "_idle_sum"},   sum,            exp_sum);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    product  = '0;
    p_ovr    = 1'b0;
    p_valid  = 1'b0;
    ds_ready = 1'b0;

    // Reset is held with random side inputs.
    for (int r = 0; r < 2; r++) begin
      start    = 1'($urandom);
      product  = $urandom;
      p_ovr    = 1'($urandom);
      p_valid  = 1'($urandom);
      ds_ready = 1'($urandom);
      @(negedge clk);
      check_eq("rst_ready", 32'(ready),     32'd0);
      check_eq("rst_valid", 32'(sum_valid), 32'd0);
      check_eq("rst_sum",   sum,            32'd0);
      check_eq("rst_ovr",   32'(sum_ovr),   32'd0);
      check_eq("rst_count", 32'(count),     32'd0);
    end
    rst      = 1'b0;
    start    = 1'b0;
    p_valid  = 1'b0;
    p_ovr    = 1'b0;
    ds_ready = 1'b0;
    @(negedge clk);
    check_eq("idle_ready", 32'(ready), 32'd0);

    // Four back-to-back pi products.
    run_vec("pi", {4{32'h0019_21FB}}, 4'b0000, 0, 0, 32'h0064_87EC, 1'b0);

    // Mixed signs, including a negative zero.
    run_vec("mixed", {32'h8000_0000, 32'h0004_0000, 32'h8008_0000, 32'h0008_0000},
            4'b0000, 0, 0, 32'h0004_0000, 1'b0);
    run_vec("cancel", {32'h8004_0000, 32'h0004_0000, 32'h8008_0000, 32'h0008_0000},
            4'b0000, 0, 0, 32'h0000_0000, 1'b0);

    // Saturation in both directions.
    run_vec("sat_pos", {4{32'h7FFF_FFFF}}, 4'b0000, 0, 0, 32'h7FFF_FFFF, 1'b1);
    run_vec("sat_neg", {4{32'hFFFF_FFFF}}, 4'b0000, 0, 0, 32'hFFFF_FFFF, 1'b1);

    // The exact full-scale magnitude does not saturate.
    run_vec("edge_max", {32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 32'h7FFF_FFFF},
            4'b0000, 0, 0, 32'h7FFF_FFFF, 1'b0);

    // A multiplier overflow flag is sticky, but only for its own run.
    run_vec("ovr_in", {4{32'h0008_0000}}, 4'b0100, 0, 0, 32'h0020_0000, 1'b1);
    run_vec("ovr_clr", {4{32'h0008_0000}}, 4'b0000, 0, 0, 32'h0020_0000, 1'b0);

    // Valid gaps, a stalled DONE and an ignored i_start.
    run_vec("gaps", {4{32'h0019_21FB}}, 4'b0000, 3, 5, 32'h0064_87EC, 1'b0);

    // A reset in mid-run abandons the run.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("mid_count0", 32'(count), 32'd0);
    p_valid = 1'b1;
    product = 32'h0008_0000;
    repeat (2) @(negedge clk);
    p_valid = 1'b0;
    check_eq("mid_count2", 32'(count), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("mid_rst_count", 32'(count), 32'd0);
    check_eq("mid_rst_ready", 32'(ready), 32'd0);
    check_eq("mid_rst_sum",   sum,        32'd0);
    run_vec("after_rst", {4{32'h0008_0000}}, 4'b0000, 0, 0, 32'h0020_0000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
